// File: rtl/M2_pkg.sv
// -----------------------------------------------------------------------------
// M2_pkg
// Shared definitions for the Milestone 2 IDCT pipeline:
//   - M2_state_type : top-level milestone 2 sequencing states
//   - WS_state_type : write-S stage states
//   - plane codes, SRAM plane base addresses and row widths (in SRAM words)
//   - block_row_offset() : shift-add computation of RB*8*ROW_WORDS
// -----------------------------------------------------------------------------
package M2_pkg;

  typedef enum logic [2:0] {
    M2_IDLE,
    M2_FETCH,
    M2_COMPUTE_T,
    M2_COMPUTE_S,
    M2_WRITE_S
  } M2_state_type;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_LEAD_IN,
    WS_RUN,
    WS_DONE
  } WS_state_type;

  localparam logic [1:0] PLANE_Y = 2'b00;
  localparam logic [1:0] PLANE_U = 2'b01;
  localparam logic [1:0] PLANE_V = 2'b10;

  localparam logic [17:0] Y_BASE       = 18'd0;
  localparam logic [17:0] U_BASE       = 18'd38400;
  localparam logic [17:0] V_BASE       = 18'd57600;
  localparam logic [17:0] Y_ROW_WORDS  = 18'd160;
  localparam logic [17:0] UV_ROW_WORDS = 18'd80;

  // Word offset of the first image row of block row rb: rb*8 rows of
  // 160 words (Y, rb*1280) or 80 words (U/V, rb*640), built from shifts.
  function automatic logic [17:0] block_row_offset(input logic [4:0] rb,
                                                   input logic uv);
    logic [17:0] rb_w;
    logic [17:0] result;
    rb_w = {13'd0, rb};
    if (uv) begin
      result = (rb_w << 9) + (rb_w << 7);
    end else begin
      result = (rb_w << 10) + (rb_w << 8);
    end
    return result;
  endfunction

endpackage

// File: rtl/ws_clip8.sv
// -----------------------------------------------------------------------------
// ws_clip8
// Converts one 32-bit signed IDCT accumulator to an 8-bit pixel:
// arithmetic shift right by 16, then saturate to 0..255.
// Ports:
//   s_data : in  32  signed accumulator from the S dual-port RAM
//   pix    : out 8   clipped pixel value
// -----------------------------------------------------------------------------
module ws_clip8 (
  input  logic [31:0] s_data,
  output logic [7:0]  pix
);

  logic signed [31:0] shifted_s;

  // Shift out the fractional bits and saturate the integer part.
  always_comb begin
    shifted_s = $signed(s_data) >>> 16;
    if (shifted_s[31]) begin
      pix = 8'd0;
    end else if (|shifted_s[30:8]) begin
      pix = 8'd255;
    end else begin
      pix = shifted_s[7:0];
    end
  end

endmodule

// File: rtl/ws_block_writer.sv
// -----------------------------------------------------------------------------
// ws_block_writer
// Write-S stage: reads the 64 IDCT results of one 8x8 block from the S
// dual-port RAM, clips each to 8 bits, packs horizontal pixel pairs (even
// column in the high byte) and writes 32 words into the Y/U/V plane of SRAM.
// Ports:
//   CLOCK_50_I      : in  1   clock
//   resetn          : in  1   asynchronous active-low reset
//   WS_start        : in  1   start pulse (accepted only when idle)
//   WS_done         : out 1   one-cycle pulse after the last write
//   WS_busy         : out 1   transfer in progress (through the done cycle)
//   plane           : in  2   00=Y, 01=U, 10=V, 11 treated as Y
//   block_row       : in  5   block row RB
//   block_col       : in  6   block column CB
//   S_read_address  : out 7   DP-RAM read address (row*8+col)
//   S_read_data     : in  32  DP-RAM data, one cycle after the address
//   SRAM_address    : out 18  SRAM word address
//   SRAM_write_data : out 16  packed pixel pair
//   SRAM_we_n       : out 1   active-low SRAM write enable
// -----------------------------------------------------------------------------
module ws_block_writer
  import M2_pkg::*;
(
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        WS_start,
  output logic        WS_done,
  output logic        WS_busy,
  input  logic [1:0]  plane,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  output logic [6:0]  S_read_address,
  input  logic [31:0] S_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  WS_state_type state_r;
  logic [6:0]   idx_r;        // index of the RAM entry arriving this cycle
  logic [7:0]   even_pix_r;   // even-column pixel waiting for its partner
  logic [17:0]  row_addr_r;   // SRAM address of column-pair 0 in the current row
  logic [17:0]  row_words_r;  // row pitch of the latched plane

  logic [17:0]  base_s;
  logic [17:0]  row_words_s;
  logic         is_uv_s;
  logic [7:0]   pix_s;

  ws_clip8 u_clip (
    .s_data (S_read_data),
    .pix    (pix_s)
  );

  // Plane decode of the start-time inputs; the reserved code falls back to Y.
  always_comb begin
    base_s      = Y_BASE;
    row_words_s = Y_ROW_WORDS;
    is_uv_s     = 1'b0;
    case (plane)
      PLANE_U: begin
        base_s      = U_BASE;
        row_words_s = UV_ROW_WORDS;
        is_uv_s     = 1'b1;
      end
      PLANE_V: begin
        base_s      = V_BASE;
        row_words_s = UV_ROW_WORDS;
        is_uv_s     = 1'b1;
      end
      default: begin
        base_s      = Y_BASE;
        row_words_s = Y_ROW_WORDS;
        is_uv_s     = 1'b0;
      end
    endcase
  end

  // Block transfer sequencer with registered RAM, SRAM and handshake outputs.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_r         <= WS_IDLE;
      idx_r           <= 7'd0;
      even_pix_r      <= 8'd0;
      row_addr_r      <= 18'd0;
      row_words_r     <= 18'd0;
      S_read_address  <= 7'd0;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
      WS_done         <= 1'b0;
      WS_busy         <= 1'b0;
    end else begin
      case (state_r)
        WS_IDLE: begin
          SRAM_we_n <= 1'b1;
          WS_done   <= 1'b0;
          if (WS_start) begin
            state_r        <= WS_LEAD_IN;
            WS_busy        <= 1'b1;
            S_read_address <= 7'd0;
            idx_r          <= 7'd0;
            row_words_r    <= row_words_s;
            // Block origin: base + RB*8*ROW_WORDS + CB*4.
            row_addr_r     <= base_s + block_row_offset(block_row, is_uv_s)
                              + {10'd0, block_col, 2'd0};
          end
        end
        WS_LEAD_IN: begin
          // Entry 0 is being read now; address entry 1 for the next cycle.
          S_read_address <= 7'd1;
          state_r        <= WS_RUN;
        end
        WS_RUN: begin
          SRAM_we_n <= 1'b1;
          if (S_read_address != 7'd63) begin
            S_read_address <= S_read_address + 7'd1;
          end
          if (idx_r[6]) begin
            // All 64 entries consumed; the final write is on the bus now.
            state_r <= WS_DONE;
            WS_done <= 1'b1;
          end else begin
            idx_r <= idx_r + 7'd1;
            if (!idx_r[0]) begin
              even_pix_r <= pix_s;
            end else begin
              SRAM_write_data <= {even_pix_r, pix_s};
              SRAM_address    <= row_addr_r + {16'd0, idx_r[2:1]};
              SRAM_we_n       <= 1'b0;
              // Last pair of a block row: step down one image row.
              if (idx_r[2:1] == 2'd3) begin
                row_addr_r <= row_addr_r + row_words_r;
              end
            end
          end
        end
        WS_DONE: begin
          WS_done <= 1'b0;
          WS_busy <= 1'b0;
          state_r <= WS_IDLE;
        end
        default: begin
          state_r   <= WS_IDLE;
          SRAM_we_n <= 1'b1;
          WS_done   <= 1'b0;
          WS_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws_block_writer.sv
// -----------------------------------------------------------------------------
// tb_ws_block_writer
// Scoreboard bench: each start pushes the 32 expected SRAM writes (address,
// data, cycle) and the expected done cycle, computed from the block/plane
// arithmetic; a monitor pops and compares whenever the DUT writes or pulses
// done. The S RAM is modelled as a synchronous-read array.
// -----------------------------------------------------------------------------
module tb_ws_block_writer;

  logic        CLOCK_50_I;
  logic        resetn;
  logic        WS_start;
  logic        WS_done;
  logic        WS_busy;
  logic [1:0]  plane;
  logic [4:0]  block_row;
  logic [5:0]  block_col;
  logic [6:0]  S_read_address;
  logic [31:0] S_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  ws_block_writer dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .resetn          (resetn),
    .WS_start        (WS_start),
    .WS_done         (WS_done),
    .WS_busy         (WS_busy),
    .plane           (plane),
    .block_row       (block_row),
    .block_col       (block_col),
    .S_read_address  (S_read_address),
    .S_read_data     (S_read_data),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  logic [31:0] mem [64];
  exp_t        exp_q [$];
  int          done_q [$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          done_count = 0;

  initial begin
    CLOCK_50_I = 1'b0;
    forever #10 CLOCK_50_I = ~CLOCK_50_I;
  end

  always @(posedge CLOCK_50_I) cyc <= cyc + 1;

  // S dual-port RAM: data appears the cycle after the address.
  always @(posedge CLOCK_50_I) S_read_data <= mem[S_read_address[5:0]];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_pix(input logic [31:0] w);
    int v;
    v = $signed(w) >>> 16;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Push the expected writes of one block whose start is sampled in cycle s.
  task automatic push_expected(input int pl, input int rb, input int cb, input int s);
    int base;
    int rw;
    exp_t e;
    if (pl == 1) begin
      base = 38400; rw = 80;
    end else if (pl == 2) begin
      base = 57600; rw = 80;
    end else begin
      base = 0; rw = 160;
    end
    for (int k = 0; k < 32; k++) begin
      int r;
      int j;
      r      = k / 4;
      j      = k % 4;
      e.addr = base + (rb * 8 + r) * rw + cb * 4 + j;
      e.data = ref_pix(mem[r * 8 + 2 * j]) * 256 + ref_pix(mem[r * 8 + 2 * j + 1]);
      e.cyc  = s + 4 + 2 * k;
      exp_q.push_back(e);
    end
    done_q.push_back(s + 67);
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 64; i++) begin
      if (mode == 0) begin
        mem[i] = i << 16;
      end else if ($urandom_range(0, 7) == 0) begin
        mem[i] = $urandom;
      end else begin
        int v;
        v = int'($urandom_range(0, 400)) - 72;
        mem[i] = (v <<< 16) | ($urandom & 32'h0000_FFFF);
      end
    end
  endtask

  // Issue a start; returns with the bench at the falling edge of cycle 1.
  task automatic start_block(input int pl, input int rb, input int cb);
    @(negedge CLOCK_50_I);
    plane     = pl[1:0];
    block_row = rb[4:0];
    block_col = cb[5:0];
    WS_start  = 1'b1;
    push_expected(pl, rb, cb, cyc);
    @(negedge CLOCK_50_I);
    WS_start  = 1'b0;
    plane     = 2'($urandom);
    block_row = 5'($urandom);
    block_col = 6'($urandom);
    check("busy_after_start", int'(WS_busy), 1);
  endtask

  task automatic wait_done(input int limit);
    int c0;
    c0 = done_count;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLOCK_50_I);
      if (done_count != c0) break;
    end
    check("done_seen", done_count - c0, 1);
    @(negedge CLOCK_50_I);
    check("writes_outstanding", exp_q.size(), 0);
    check("done_outstanding", done_q.size(), 0);
    check("busy_after_done", int'(WS_busy), 0);
  endtask

  task automatic run_block(input int pl, input int rb, input int cb);
    start_block(pl, rb, cb);
    wait_done(120);
  endtask

  initial begin
    exp_t e;
    int   c0;
    resetn    = 1'b0;
    WS_start  = 1'b0;
    plane     = 2'd0;
    block_row = 5'd0;
    block_col = 6'd0;
    fill(0);

    fork
      // Monitor: compare every DUT write and done pulse to the scoreboard.
      forever begin
        @(negedge CLOCK_50_I);
        if (resetn) begin
          if (!SRAM_we_n) begin
            if (exp_q.size() == 0) begin
              check("unexpected_write", int'(SRAM_address), -1);
            end else begin
              e = exp_q.pop_front();
              check("write_addr", int'(SRAM_address), e.addr);
              check("write_data", int'(SRAM_write_data), e.data);
              check("write_cycle", cyc, e.cyc);
            end
          end
          if (WS_done) begin
            done_count++;
            if (done_q.size() == 0) begin
              check("unexpected_done", cyc, -1);
            end else begin
              check("done_cycle", cyc, done_q.pop_front());
              check("busy_in_done", int'(WS_busy), 1);
            end
          end
        end
      end
    join_none

    #15;
    check("rst_we_n", int'(SRAM_we_n), 1);
    check("rst_addr", int'(SRAM_address), 0);
    check("rst_wdata", int'(SRAM_write_data), 0);
    check("rst_raddr", int'(S_read_address), 0);
    check("rst_done", int'(WS_done), 0);
    check("rst_busy", int'(WS_busy), 0);
    repeat (3) @(negedge CLOCK_50_I);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);

    // Ramp data, Y block (0,0).
    fill(0);
    run_block(0, 0, 0);

    // Clipping corners in the first two words.
    fill(1);
    mem[0] = 32'hFFFF_0000;
    mem[1] = 32'h0120_0000;
    mem[2] = 32'h00FF_FFFF;
    mem[3] = 32'h0000_FFFF;
    run_block(0, 3, 5);

    // Plane corners and the reserved plane code.
    fill(1);
    run_block(2, 29, 19);
    fill(1);
    run_block(1, 1, 2);
    fill(1);
    run_block(3, 29, 39);

    // A second start mid-transfer must be ignored.
    fill(1);
    start_block(0, 7, 11);
    repeat (29) @(negedge CLOCK_50_I);
    plane     = 2'd1;
    block_row = 5'd2;
    block_col = 6'd3;
    WS_start  = 1'b1;
    @(negedge CLOCK_50_I);
    WS_start  = 1'b0;
    wait_done(120);

    // Reset in cycle 20 aborts the block with no done pulse.
    fill(1);
    start_block(1, 4, 9);
    repeat (18) @(negedge CLOCK_50_I);
    @(posedge CLOCK_50_I);
    #1;
    resetn = 1'b0;
    #1;
    check("abort_we_n", int'(SRAM_we_n), 1);
    check("abort_busy", int'(WS_busy), 0);
    check("abort_done", int'(WS_done), 0);
    exp_q.delete();
    done_q.delete();
    c0 = done_count;
    repeat (3) @(negedge CLOCK_50_I);
    resetn = 1'b1;
    repeat (80) @(negedge CLOCK_50_I);
    check("no_done_after_abort", done_count, c0);
    fill(1);
    run_block(0, 12, 20);

    // Randomized blocks.
    for (int n = 0; n < 6; n++) begin
      int pl;
      int rb;
      int cb;
      pl = $urandom_range(0, 3);
      rb = $urandom_range(0, 29);
      cb = (pl == 1 || pl == 2) ? $urandom_range(0, 19) : $urandom_range(0, 39);
      fill(1);
      run_block(pl, rb, cb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
